// File: rtl/window_stream_arbiter.sv
// Round-robin arbiter that locks one serializer onto the bus for a full BEATS-beat window burst.
// One-cycle arbitration in IDLE; data is combinational pass-through; out_ready goes straight back to the granted level.
module window_stream_arbiter #(
  parameter int BUS_WIDTH = 128,
  parameter int LEVELS    = 7,
  parameter int BEATS     = 10,
  parameter int LVL_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEVELS-1:0]           level_enable,
  input  logic [LEVELS-1:0]           in_valid,
  input  logic [BUS_WIDTH*LEVELS-1:0] in_stream,
  output logic [LEVELS-1:0]           in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        out_stream,
  output logic [LVL_W-1:0]            out_level,
  output logic                        out_last,
  output logic                        busy,
  output logic [CNT_W-1:0]            windows_sent
);

  localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [LVL_W-1:0]  grant;
  logic [LVL_W-1:0]  last_grant;
  logic [BC_W-1:0]   beat_cnt;
  logic [LEVELS-1:0] req;
  logic [LVL_W-1:0]  nxt_grant;
  logic              handshake;

  assign req = in_valid & level_enable;

  // Rotating priority: start one past the previous winner, wrap at LEVELS.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    nxt_grant = '0;
    for (int i = 0; i < LEVELS; i++) begin
      idx = (int'(last_grant) + 1 + i) % LEVELS;
      if (!found && req[idx]) begin
        found     = 1'b1;
        nxt_grant = LVL_W'(idx);
      end
    end
  end

  always_comb begin
    busy       = (state == BURST);
    out_level  = grant;
    out_valid  = busy & in_valid[grant];
    out_stream = busy ? in_stream[grant*BUS_WIDTH +: BUS_WIDTH] : '0;
    in_ready   = busy ? (LEVELS'(out_ready) << grant) : '0;
    out_last   = out_valid & (beat_cnt == BC_W'(BEATS - 1));
    handshake  = out_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LVL_W'(LEVELS - 1);
      beat_cnt     <= '0;
      windows_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= nxt_grant;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // Grant is held until the last beat regardless of valid/enable changes.
          if (handshake) begin
            if (out_last) begin
              state      <= IDLE;
              last_grant <= grant;
              beat_cnt   <= '0;
              if (windows_sent != '1)
                windows_sent <= windows_sent + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_stream_arbiter.sv
// Directed bench for window_stream_arbiter: round-robin order, burst locking, stalls, masking, reset and counter saturation.
module tb_window_stream_arbiter;

  localparam int BW = 128;
  localparam int LV = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [LV-1:0] level_enable, in_valid, in_ready;
  logic [BW*LV-1:0] in_stream;
  logic          out_valid, out_ready, out_last, busy;
  logic [BW-1:0] out_stream;
  logic [2:0]    out_level;
  logic [15:0]   windows_sent;

  logic [LV-1:0] level_enable_s, in_valid_s, in_ready_s;
  logic          out_valid_s, out_ready_s, out_last_s, busy_s;
  logic [BW-1:0] out_stream_s;
  logic [2:0]    out_level_s;
  logic [3:0]    windows_sent_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  window_stream_arbiter #(.BUS_WIDTH(BW), .LEVELS(LV), .BEATS(10), .LVL_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .level_enable(level_enable), .in_valid(in_valid),
    .in_stream(in_stream), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_stream(out_stream), .out_level(out_level),
    .out_last(out_last), .busy(busy), .windows_sent(windows_sent)
  );

  // One-beat bursts with a narrow counter so saturation is reachable quickly.
  window_stream_arbiter #(.BUS_WIDTH(BW), .LEVELS(LV), .BEATS(1), .LVL_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .level_enable(level_enable_s), .in_valid(in_valid_s),
    .in_stream(in_stream), .in_ready(in_ready_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .out_stream(out_stream_s), .out_level(out_level_s),
    .out_last(out_last_s), .busy(busy_s), .windows_sent(windows_sent_s)
  );

  function automatic logic [BW-1:0] lvl_data(input int j);
    return {16{8'(8'h10 + j)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one granted beat of level lv at beat index k, then advances a cycle.
  task automatic beat(input string tag, input int lv, input int k);
    logic [12:0] got, exp;
    #1;
    got = {busy, out_valid, out_level, out_last, in_ready};
    exp = {1'b1, 1'b1, 3'(lv), (k == 9), 7'(1 << lv)};
    n_vec++;
    if (got !== exp || out_stream !== lvl_data(lv)) begin
      n_err++;
      $display("FAIL %s lv=%0d beat=%0d got busy/vld/lvl/last/rdy=%h data=%h, expected %h data=%h",
               tag, lv, k, got, out_stream, exp, lvl_data(lv));
    end
    tick();
  endtask

  task automatic idle_gap(input string tag);
    #1;
    n_vec++;
    if ({busy, out_valid, in_ready} !== 9'h0) begin
      n_err++;
      $display("FAIL %s_gap got busy=%b vld=%b rdy=%h, expected 0 0 00", tag, busy, out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; level_enable = '1; in_valid = '1; out_ready = 1'b1;
    level_enable_s = '1; in_valid_s = '0; out_ready_s = 1'b1;
    tick(); tick();
    n_vec++;
    if ({busy, out_valid, in_ready, out_level, out_last, windows_sent} !== 28'h0 || out_stream !== '0) begin
      n_err++;
      $display("FAIL reset got busy=%b vld=%b rdy=%h lvl=%0d last=%b win=%0d data=%h, expected all 0",
               busy, out_valid, in_ready, out_level, out_last, windows_sent, out_stream);
    end
    n_vec++;
    if (windows_sent_s !== 4'd0 || busy_s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sat got win=%0d busy=%b, expected 0 0", windows_sent_s, busy_s);
    end
    rst = 1'b0; in_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    in_valid = '1;
    tick();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 10; k++) beat("rr", b % 7, k);
      if (b == 7) in_valid = '0;
      idle_gap("rr");
    end
    n_vec++;
    if (windows_sent !== 16'd8) begin
      n_err++;
      $display("FAIL rr_windows got %0d, expected 8", windows_sent);
    end
  endtask

  task automatic test_backpressure();
    int done;
    logic [12:0] got, exp;
    done = 0;
    in_valid = 7'h08; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 1);
      #1;
      got = {busy, out_valid, out_level, out_last, in_ready};
      exp = {1'b1, 1'b1, 3'd3, (done == 9), out_ready ? 7'h08 : 7'h00};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bp cyc=%0d got %h, expected %h", i, got, exp);
      end
      if (out_ready) done++;
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || windows_sent !== 16'd9) begin
      n_err++;
      $display("FAIL bp_end got busy=%b win=%0d, expected 0 9", busy, windows_sent);
    end
    tick();
  endtask

  task automatic test_stall();
    in_valid = 7'h04;
    tick();
    in_valid = 7'h24;
    for (int k = 0; k < 4; k++) beat("stall_pre", 2, k);
    in_valid = 7'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if ({busy, out_valid, out_level, out_last, in_ready} !== {1'b1, 1'b0, 3'd2, 1'b0, 7'h04}) begin
        n_err++;
        $display("FAIL stall cyc=%0d got busy=%b vld=%b lvl=%0d last=%b rdy=%h, expected 1 0 2 0 04",
                 i, busy, out_valid, out_level, out_last, in_ready);
      end
      tick();
    end
    in_valid = 7'h24;
    for (int k = 4; k < 10; k++) beat("stall_post", 2, k);
    idle_gap("stall");
    for (int k = 0; k < 10; k++) beat("stall_next", 5, k);
    in_valid = '0;
    idle_gap("stall_end");
    n_vec++;
    if (windows_sent !== 16'd11) begin
      n_err++;
      $display("FAIL stall_windows got %0d, expected 11", windows_sent);
    end
  endtask

  task automatic test_mid_reset();
    in_valid = 7'h10;
    tick();
    for (int k = 0; k < 6; k++) beat("mrst_pre", 4, k);
    rst = 1'b1; in_valid = 7'h38;
    tick();
    n_vec++;
    if ({busy, out_valid, in_ready, out_level, out_last} !== 11'h0 || windows_sent !== 16'd0) begin
      n_err++;
      $display("FAIL mrst got busy=%b vld=%b rdy=%h lvl=%0d last=%b win=%0d, expected 0 0 00 0 0 0",
               busy, out_valid, in_ready, out_level, out_last, windows_sent);
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) beat("mrst_post", 3, k);
    in_valid = '0;
    idle_gap("mrst");
    n_vec++;
    if (windows_sent !== 16'd1) begin
      n_err++;
      $display("FAIL mrst_windows got %0d, expected 1", windows_sent);
    end
  endtask

  task automatic test_mask();
    int seq [5] = '{0, 2, 4, 6, 0};
    rst = 1'b1;
    tick();
    rst = 1'b0; level_enable = 7'b1010101; in_valid = '1;
    tick();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 10; k++) beat("mask", seq[b], k);
      if (b == 4) in_valid = '0;
      idle_gap("mask");
    end
    level_enable = '1;
  endtask

  task automatic test_saturation();
    in_valid_s = '1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 28 || t == 30 || t == 40) begin
        n_vec++;
        if (windows_sent_s !== ((t == 28) ? 4'd14 : 4'd15)) begin
          n_err++;
          $display("FAIL sat t=%0d got %0d, expected %0d", t, windows_sent_s, (t == 28) ? 14 : 15);
        end
      end
    end
    in_valid_s = '0;
  endtask

  initial begin
    for (int j = 0; j < LV; j++) in_stream[j*BW +: BW] = lvl_data(j);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_mid_reset();
    test_mask();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
